// File: rtl/seven_seg_scanner.sv
// rtl/seven_seg_scanner.sv - multiplexed seven-segment driver with refresh scan and brightness PWM
//
// Ports:
//   clk          system clock
//   rst          synchronous active-high reset
//   value        hex nibbles, digit i = value[4i+3:4i], digit 0 rightmost
//   dp_in        decimal point request per digit, active-high
//   load         one-cycle strobe capturing value and dp_in
//   brightness   on-phases per digit slot (0 dark .. 15)
//   seg          segments {g,f,e,d,c,b,a}, active-low, registered
//   dp           decimal point, active-low, registered
//   an           anode enables, active-low, registered
//   frame_start  one-cycle pulse with the first output of each frame
module seven_seg_scanner #(
  parameter int NUM_DIGITS    = 4,
  parameter int PHASE_LEN     = 6250,
  parameter int BLANK_LEADING = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    load,
  input  logic [3:0]              brightness,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_start
);

  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int PW = (PHASE_LEN > 1) ? $clog2(PHASE_LEN) : 1;
  localparam logic [PW-1:0] PCNT_MAX = PW'(PHASE_LEN - 1);
  localparam logic [IW-1:0] IDX_MAX  = IW'(NUM_DIGITS - 1);

  logic [PW-1:0] pcnt;
  logic [3:0]    phase;
  logic [IW-1:0] idx;
  logic          pcnt_wrap;
  logic          phase_wrap;
  logic          frame_end;
  logic          wrap_d;

  logic [4*NUM_DIGITS-1:0] stage_val;
  logic [NUM_DIGITS-1:0]   stage_dp;
  logic                    pending;
  logic [4*NUM_DIGITS-1:0] shadow_val;
  logic [NUM_DIGITS-1:0]   shadow_dp;

  logic [NUM_DIGITS-1:0]   blank;
  logic                    zero_run;
  logic [3:0]              cur_nib;
  logic                    cur_dp;
  logic [NUM_DIGITS-1:0]   an_next;

  function automatic logic [6:0] decode(input logic [3:0] n);
    case (n)
      4'h0: decode = 7'h40;
      4'h1: decode = 7'h79;
      4'h2: decode = 7'h24;
      4'h3: decode = 7'h30;
      4'h4: decode = 7'h19;
      4'h5: decode = 7'h12;
      4'h6: decode = 7'h02;
      4'h7: decode = 7'h78;
      4'h8: decode = 7'h00;
      4'h9: decode = 7'h10;
      4'hA: decode = 7'h08;
      4'hB: decode = 7'h03;
      4'hC: decode = 7'h46;
      4'hD: decode = 7'h21;
      4'hE: decode = 7'h06;
      default: decode = 7'h0E;
    endcase
  endfunction

  assign pcnt_wrap  = (pcnt == PCNT_MAX);
  assign phase_wrap = pcnt_wrap && (phase == 4'hF);
  assign frame_end  = phase_wrap && (idx == IDX_MAX);

  // Scan counters: pcnt -> phase -> idx
  always_ff @(posedge clk) begin
    if (rst) begin
      pcnt   <= '0;
      phase  <= '0;
      idx    <= '0;
      wrap_d <= 1'b0;
    end else begin
      pcnt   <= pcnt_wrap ? '0 : pcnt + PW'(1);
      wrap_d <= frame_end;
      if (pcnt_wrap)
        phase <= phase + 4'd1;
      if (phase_wrap)
        idx <= (idx == IDX_MAX) ? '0 : idx + IW'(1);
    end
  end

  // Staging/shadow pair: the shadow only moves at frame end so a frame is
  // never drawn from two different values. A load coinciding with frame
  // end bypasses staging so it is not delayed by a whole extra frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      stage_val  <= '0;
      stage_dp   <= '0;
      pending    <= 1'b0;
      shadow_val <= '0;
      shadow_dp  <= '0;
    end else begin
      if (load) begin
        stage_val <= value;
        stage_dp  <= dp_in;
      end
      if (frame_end) begin
        pending <= 1'b0;
        if (load) begin
          shadow_val <= value;
          shadow_dp  <= dp_in;
        end else if (pending) begin
          shadow_val <= stage_val;
          shadow_dp  <= stage_dp;
        end
      end else if (load) begin
        pending <= 1'b1;
      end
    end
  end

  // Leading-zero mask: walk from the most significant digit down while the
  // nibbles stay zero; digit 0 is never part of the run.
  always_comb begin
    blank    = '0;
    zero_run = 1'b1;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      zero_run = zero_run && (shadow_val[4*i +: 4] == 4'h0);
      blank[i] = (BLANK_LEADING != 0) && zero_run;
    end
  end

  always_comb begin
    cur_nib = 4'h0;
    cur_dp  = 1'b0;
    an_next = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IW'(i)) begin
        cur_nib    = shadow_val[4*i +: 4];
        cur_dp     = shadow_dp[i];
        // phase 15 can never be below a 4-bit brightness: built-in guard
        an_next[i] = !((phase < brightness) && !blank[i]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seg         <= 7'h7F;
      dp          <= 1'b1;
      an          <= '1;
      frame_start <= 1'b0;
    end else begin
      seg         <= decode(cur_nib);
      dp          <= ~cur_dp;
      an          <= an_next;
      frame_start <= wrap_d;
    end
  end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// tb/tb_seven_seg_scanner.sv - self-checking bench for seven_seg_scanner
module tb_seven_seg_scanner;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] value = 16'h0;
  logic [3:0]  dp_in = 4'h0;
  logic        load = 1'b0;
  logic [3:0]  brightness = 4'd15;
  logic [6:0]  seg, seg2;
  logic        dp, dp2;
  logic [3:0]  an, an2;
  logic        frame_start, frame_start2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  seven_seg_scanner #(.NUM_DIGITS(4), .PHASE_LEN(2), .BLANK_LEADING(1)) dut (
    .clk(clk), .rst(rst), .value(value), .dp_in(dp_in), .load(load),
    .brightness(brightness), .seg(seg), .dp(dp), .an(an), .frame_start(frame_start)
  );

  seven_seg_scanner #(.NUM_DIGITS(4), .PHASE_LEN(2), .BLANK_LEADING(0)) dut_nb (
    .clk(clk), .rst(rst), .value(value), .dp_in(dp_in), .load(load),
    .brightness(brightness), .seg(seg2), .dp(dp2), .an(an2), .frame_start(frame_start2)
  );

  // One row per frame: stimulus (brightness, scheduled loads at output
  // cycle c of the frame) and the display expected for that frame.
  typedef struct {
    string       name;
    logic [3:0]  bright;
    int          ld1_c;
    logic [15:0] ld1_v;
    logic [3:0]  ld1_dp;
    int          ld2_c;
    logic [15:0] ld2_v;
    logic [3:0]  ld2_dp;
    logic [27:0] segs;   // {digit3..digit0}
    logic [3:0]  dpn;    // active-low dp per digit
    logic [3:0]  lit;    // digits not blanked (blanking instance)
  } vec_t;

  vec_t rows[8];
  vec_t exp_q[$];

  function automatic vec_t mk(string n, logic [3:0] b, int c1, logic [15:0] v1, logic [3:0] d1,
                              int c2, logic [15:0] v2, logic [3:0] d2,
                              logic [27:0] s, logic [3:0] dn, logic [3:0] l);
    vec_t r;
    r.name = n; r.bright = b;
    r.ld1_c = c1; r.ld1_v = v1; r.ld1_dp = d1;
    r.ld2_c = c2; r.ld2_v = v2; r.ld2_dp = d2;
    r.segs = s; r.dpn = dn; r.lit = l;
    return r;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  task automatic wait_fs(output bit ok);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_start && n < 300);
    ok = frame_start;
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL frame_start_timeout: got no pulse in %0d cycles required one", n);
    end
  endtask

  task automatic check_frame(input int r);
    vec_t e;
    bit ok;
    int s, ph, stray;
    logic [3:0] lit, an_e, an_a;
    logic [6:0] seg_e, seg_a;
    logic dp_e, dp_a, fs_a;
    bit bad[2];
    logic [3:0] b_an[2], b_an_e[2];
    logic [6:0] b_seg[2], b_seg_e[2];
    logic b_dp[2], b_dp_e[2];
    stray = 0;
    wait_fs(ok);
    if (!ok) return;
    e = exp_q.pop_front();
    for (int c = 0; c < 128; c++) begin
      if (c > 0) @(negedge clk);
      s  = c / 32;
      ph = (c % 32) / 2;
      if (c % 32 == 0) begin
        bad[0] = 1'b0;
        bad[1] = 1'b0;
      end
      for (int d = 0; d < 2; d++) begin
        lit   = (d == 0) ? e.lit : 4'hF;
        an_e  = (lit[s] && (ph < int'(e.bright))) ? ~(4'b0001 << s) : 4'hF;
        seg_e = e.segs[s*7 +: 7];
        dp_e  = e.dpn[s];
        an_a  = (d == 0) ? an : an2;
        seg_a = (d == 0) ? seg : seg2;
        dp_a  = (d == 0) ? dp : dp2;
        fs_a  = (d == 0) ? frame_start : frame_start2;
        if (c > 0 && fs_a) stray++;
        if (!bad[d] && (an_a !== an_e || seg_a !== seg_e || dp_a !== dp_e)) begin
          bad[d] = 1'b1;
          b_an[d] = an_a; b_an_e[d] = an_e;
          b_seg[d] = seg_a; b_seg_e[d] = seg_e;
          b_dp[d] = dp_a; b_dp_e[d] = dp_e;
        end
        if (c % 32 == 31) begin
          checks++;
          if (bad[d]) begin
            failures++;
            $display("FAIL %s slot%0d blank%0d: got an=%h seg=%h dp=%b required an=%h seg=%h dp=%b",
                     e.name, s, 1 - d, b_an[d], b_seg[d], b_dp[d], b_an_e[d], b_seg_e[d], b_dp_e[d]);
          end
        end
      end
      if (c == rows[r].ld1_c) begin
        load = 1'b1; value = rows[r].ld1_v; dp_in = rows[r].ld1_dp;
      end else if (c == rows[r].ld2_c) begin
        load = 1'b1; value = rows[r].ld2_v; dp_in = rows[r].ld2_dp;
      end else begin
        load = 1'b0;
      end
    end
    chk({e.name, "_stray_frame_start"}, 16'(stray), 16'd0);
  endtask

  initial begin
    int k;
    rows[0] = mk("reset_zero",   4'd15, 60, 16'hA3F0, 4'b0100, -1, 16'h0, 4'h0,
                 {7'h40, 7'h40, 7'h40, 7'h40}, 4'b1111, 4'b0001);
    rows[1] = mk("decode_A3F0",  4'd15, 40, 16'h1234, 4'h0, 43, 16'h5678, 4'h0,
                 {7'h08, 7'h30, 7'h0E, 7'h40}, 4'b1011, 4'b1111);
    rows[2] = mk("tear_5678",    4'd15, 126, 16'h1234, 4'b0001, -1, 16'h0, 4'h0,
                 {7'h12, 7'h02, 7'h78, 7'h00}, 4'b1111, 4'b1111);
    rows[3] = mk("fe_load_1234", 4'd15, -1, 16'h0, 4'h0, -1, 16'h0, 4'h0,
                 {7'h79, 7'h24, 7'h30, 7'h19}, 4'b1110, 4'b1111);
    rows[4] = mk("bright4",      4'd4,  -1, 16'h0, 4'h0, -1, 16'h0, 4'h0,
                 {7'h79, 7'h24, 7'h30, 7'h19}, 4'b1110, 4'b1111);
    rows[5] = mk("bright0",      4'd0,  126, 16'h0070, 4'h0, -1, 16'h0, 4'h0,
                 {7'h79, 7'h24, 7'h30, 7'h19}, 4'b1110, 4'b1111);
    rows[6] = mk("blank_0070",   4'd15, -1, 16'h0, 4'h0, -1, 16'h0, 4'h0,
                 {7'h40, 7'h40, 7'h78, 7'h40}, 4'b1111, 4'b0011);
    rows[7] = mk("after_reset",  4'd15, -1, 16'h0, 4'h0, -1, 16'h0, 4'h0,
                 {7'h40, 7'h40, 7'h40, 7'h40}, 4'b1111, 4'b0001);

    // Reset held for three cycles
    repeat (3) @(negedge clk);
    chk("rst_an", {12'h0, an}, 16'hF);
    chk("rst_seg", {9'h0, seg}, 16'h7F);
    chk("rst_dp_fs", {14'h0, dp, frame_start}, 16'b10);
    chk("rst_an_nb", {12'h0, an2}, 16'hF);
    rst = 1'b0;
    @(negedge clk);
    chk("first_an", {12'h0, an}, 16'hE);
    chk("first_seg", {9'h0, seg}, 16'h40);

    for (int r = 0; r < 7; r++) begin
      brightness = rows[r].bright;
      exp_q.push_back(rows[r]);
      check_frame(r);
    end

    // Reset during slot 2 with a load pending
    begin
      bit ok;
      wait_fs(ok);
      repeat (69) @(negedge clk);
      load = 1'b1; value = 16'hBEEF; dp_in = 4'hF;
      @(negedge clk);
      load = 1'b0;
      repeat (5) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_an", {12'h0, an}, 16'hF);
      chk("midrst_seg", {9'h0, seg}, 16'h7F);
      chk("midrst_dp_fs", {14'h0, dp, frame_start}, 16'b10);
      rst = 1'b0;
      @(negedge clk);
      chk("restart_an", {12'h0, an}, 16'hE);
      chk("restart_seg_dp", {8'h0, seg, dp}, {8'h0, 7'h40, 1'b1});
      chk("restart_an_nb", {12'h0, an2}, 16'hE);
      k = 0;
      do begin
        @(negedge clk);
        k++;
      end while (!frame_start && k < 300);
      chk("restart_frame_period", 16'(k), 16'd128);
    end

    brightness = rows[7].bright;
    exp_q.push_back(rows[7]);
    check_frame(7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
